fp_int_acc_sat: RTL
===================

Name: fp_int_acc_sat

Overview:
Parametrised, self-contained FP-INT accumulator that supersedes the single-width block in the MAC datapath. Holds its own accumulator value and exponent internally, so no external feedback path is needed. Accepts one signed-magnitude product term per valid/ready handshake and aligns the term and the accumulator to the smaller exponent. Adds with two's-complement saturation and a sticky overflow flag, and supports restarting or clearing an accumulation at any time.

Parameters:
EXP_W, 5, exponent width (unsigned, biased)
IN_W, 14, magnitude width of incoming product term
ACC_W, 32, signed two's-complement accumulator width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of accumulator, exponent, ovf; aborts in-flight op
in_valid  in  1  input term valid
in_ready  out  1  block can accept a term
in_first  in  1  term starts a new accumulation (prior acc discarded)
in_sign  in  1  1 = subtract term
in_exp  in  EXP_W  term exponent
in_mag  in  IN_W  term magnitude (unsigned)
out_valid  out  1  one-cycle pulse: acc_out/exp_out updated
acc_out  out  ACC_W  accumulator value (signed)
exp_out  out  EXP_W  accumulator exponent
ovf  out  1  sticky saturation flag

Behaviour:
- Reset (async, rst=1): acc_out=0, exp_out=0, ovf=0, out_valid=0, in_ready=1, state IDLE; holds while rst high.
- FSM: IDLE -> ALIGN -> ADD -> IDLE. in_ready=1 only in IDLE; accept = in_valid & in_ready.
- Accept at edge k (IDLE): capture sign/exp/mag/first; go ALIGN.
- ALIGN (edge k+1): register aligned operands and new exponent:
  - in_first=1: acc operand=0, term unshifted, new exp=in_exp.
  - in_exp >= exp_q: term << (in_exp-exp_q); acc unshifted; exp unchanged.
  - in_exp < exp_q: acc << (exp_q-in_exp); term unshifted; exp=in_exp.
  - Subtraction of exponents done at EXP_W+1 bits; no wrap.
- Shift saturation: shifted value not representable in ACC_W signed (bits lost or sign changed, including any shift >= ACC_W with nonzero operand) -> clamp to +max/-min per operand sign, flag saturation.
- ADD (edge k+2): sum = acc_op ± term_op computed at ACC_W+1 bits; on out-of-range, clamp to 0x7FF..F / 0x800..0 and flag. acc_out, exp_out update; ovf |= any saturation flag; out_valid=1 for the cycle after edge k+2; state -> IDLE (in_ready=1 in that same cycle).
- Throughput: one term per 3 cycles; in_valid while busy is ignored (not queued).
- in_first also clears ovf for the new accumulation.
- clr: has priority over everything except rst. Next edge: acc=0, exp=0, ovf=0, IDLE, no out_valid; a simultaneous in_valid is not accepted.
- Zero magnitude term: still aligns (may lower exponent and shift acc); documented, not special-cased.
- Outputs stable between updates; all outputs registered.

Decomposition:
- Package fp_int_pkg: EXP_W/IN_W/ACC_W defaults, FSM state encoding (IDLE, ALIGN, ADD), ACC_MAX/ACC_MIN constants.
- Sub-module fp_int_sat_shl: combinational saturating left shift (signed ACC_W value, shift amount EXP_W+1 bits -> result, sat flag); instantiated twice (acc and term paths).

Test Plan:
- Reset: assert rst mid-ADD -> immediately acc_out=0, exp_out=0, ovf=0, out_valid=0, in_ready=1.
- First term: in_first=1, sign0, exp=10, mag=100 accepted at edge k -> out_valid in cycle after k+2, acc_out=100, exp_out=10; next term sign0, exp=12, mag=3 -> acc_out=112, exp_out=10.
- Lower exponent: from acc=112/exp=10, term sign1, exp=8, mag=1 -> acc_out=447, exp_out=8, ovf=0.
- Saturation: acc=100/exp=0, term sign0, exp=31, mag=1 -> acc_out=0x7FFFFFFF, ovf=1; following in_first term exp=3, mag=5 -> acc_out=5, exp_out=3, ovf=0.
- Clear mid-op: accept term, assert clr during ALIGN -> no out_valid, acc_out=0, exp_out=0, in_ready=1 next cycle.
- Busy/ignore: hold in_valid high 6 cycles with differing terms -> exactly two accepts (cycles 0 and 3); clr and in_valid same cycle -> term dropped.

Source files
------------

// File: rtl/fp_int_pkg.sv
// Shared definitions for the FP-INT saturating accumulator:
// default widths, FSM encoding and clamp limits.
package fp_int_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int IN_W_DEF  = 14;
  localparam int ACC_W_DEF = 32;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2
  } state_t;

endpackage

// File: rtl/fp_int_sat_shl.sv
// Saturating left shift of a signed ACC_W value.
// Clamps to +max/-min by operand sign when bits or the sign would be lost.
module fp_int_sat_shl #(
  parameter int ACC_W = 32,
  parameter int EXP_W = 5
) (
  input  logic [ACC_W-1:0] i_val,
  input  logic [EXP_W:0]   i_sh,
  output logic [ACC_W-1:0] o_res,
  output logic             o_sat
);

  logic [31:0]      w_sh32;
  logic [ACC_W-1:0] w_shl;
  logic [ACC_W-1:0] w_back;
  logic [ACC_W-1:0] w_clamp;

  assign w_sh32  = 32'(i_sh);
  assign w_clamp = i_val[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  // Shift, then shift back arithmetically: a mismatch means information was lost.
  always_comb begin
    w_shl  = i_val << w_sh32;
    w_back = $signed(w_shl) >>> w_sh32;
    o_res  = i_val;
    o_sat  = 1'b0;
    if (i_val == {ACC_W{1'b0}}) begin
      o_res = {ACC_W{1'b0}};
      o_sat = 1'b0;
    end else if (w_sh32 >= 32'(ACC_W)) begin
      o_res = w_clamp;
      o_sat = 1'b1;
    end else if (w_back == i_val) begin
      o_res = w_shl;
      o_sat = 1'b0;
    end else begin
      o_res = w_clamp;
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/fp_int_acc_sat.sv
// Self-contained FP-INT accumulator: aligns a signed-magnitude term and the held
// accumulator to the smaller exponent, then adds with saturation (3-cycle op).
module fp_int_acc_sat
  import fp_int_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [IN_W-1:0]  in_mag,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             ovf
);

  state_t           r_state, w_state_nxt;
  logic             r_in_ready, r_out_valid, w_in_ready_nxt, w_out_valid_nxt;
  logic             r_sign, r_first, r_sat_al, r_ovf;
  logic [EXP_W-1:0] r_exp_in, r_exp, r_exp_new, w_exp_new_nxt;
  logic [IN_W-1:0]  r_mag;
  logic [ACC_W-1:0] r_acc, r_acc_op, r_term_op, w_acc_op_nxt;
  logic [ACC_W-1:0] w_term_ext, w_term_shl, w_acc_shl, w_sum_sat;
  logic [EXP_W:0]   w_term_sh, w_acc_sh;
  logic             w_term_sat, w_acc_sat, w_sat_al_nxt, w_accept, w_add_ovf;
  logic [ACC_W:0]   w_sum;

  assign w_accept   = in_valid & r_in_ready & ~clr;
  assign w_term_ext = {{(ACC_W-IN_W){1'b0}}, r_mag};

  // Only the operand with the larger exponent is shifted, by the exponent gap.
  always_comb begin
    w_term_sh = {(EXP_W+1){1'b0}};
    w_acc_sh  = {(EXP_W+1){1'b0}};
    if (r_first) begin
      w_term_sh = {(EXP_W+1){1'b0}};
    end else if (r_exp_in >= r_exp) begin
      w_term_sh = {1'b0, r_exp_in} - {1'b0, r_exp};
    end else begin
      w_acc_sh = {1'b0, r_exp} - {1'b0, r_exp_in};
    end
  end

  fp_int_sat_shl #(.ACC_W(ACC_W), .EXP_W(EXP_W)) u_shl_term (
    .i_val(w_term_ext), .i_sh(w_term_sh), .o_res(w_term_shl), .o_sat(w_term_sat)
  );

  fp_int_sat_shl #(.ACC_W(ACC_W), .EXP_W(EXP_W)) u_shl_acc (
    .i_val(r_acc), .i_sh(w_acc_sh), .o_res(w_acc_shl), .o_sat(w_acc_sat)
  );

  // Aligned operand and exponent selection for the ALIGN stage.
  always_comb begin
    w_acc_op_nxt  = w_acc_shl;
    w_exp_new_nxt = r_exp;
    w_sat_al_nxt  = w_term_sat | w_acc_sat;
    if (r_first) begin
      w_acc_op_nxt  = {ACC_W{1'b0}};
      w_exp_new_nxt = r_exp_in;
      w_sat_al_nxt  = w_term_sat;
    end else if (r_exp_in >= r_exp) begin
      w_exp_new_nxt = r_exp;
    end else begin
      w_exp_new_nxt = r_exp_in;
    end
  end

  // One guard bit detects overflow of the signed sum.
  always_comb begin
    if (r_sign) begin
      w_sum = {r_acc_op[ACC_W-1], r_acc_op} - {r_term_op[ACC_W-1], r_term_op};
    end else begin
      w_sum = {r_acc_op[ACC_W-1], r_acc_op} + {r_term_op[ACC_W-1], r_term_op};
    end
    w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (!w_add_ovf) begin
      w_sum_sat = w_sum[ACC_W-1:0];
    end else if (w_sum[ACC_W]) begin
      w_sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      w_sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; clr always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = w_accept ? ST_ALIGN : ST_IDLE;
        ST_ALIGN: w_state_nxt = ST_ADD;
        ST_ADD:   w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs, computed one cycle ahead so they can be registered.
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = 1'b0;
    if (clr) begin
      w_out_valid_nxt = 1'b0;
    end else begin
      w_out_valid_nxt = (r_state == ST_ADD);
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Datapath: capture, align and accumulate stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign    <= 1'b0;
      r_first   <= 1'b0;
      r_exp_in  <= {EXP_W{1'b0}};
      r_mag     <= {IN_W{1'b0}};
      r_acc_op  <= {ACC_W{1'b0}};
      r_term_op <= {ACC_W{1'b0}};
      r_exp_new <= {EXP_W{1'b0}};
      r_sat_al  <= 1'b0;
      r_acc     <= {ACC_W{1'b0}};
      r_exp     <= {EXP_W{1'b0}};
      r_ovf     <= 1'b0;
    end else if (clr) begin
      r_acc <= {ACC_W{1'b0}};
      r_exp <= {EXP_W{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sign   <= in_sign;
            r_first  <= in_first;
            r_exp_in <= in_exp;
            r_mag    <= in_mag;
          end
        end
        ST_ALIGN: begin
          r_acc_op  <= w_acc_op_nxt;
          r_term_op <= w_term_shl;
          r_exp_new <= w_exp_new_nxt;
          r_sat_al  <= w_sat_al_nxt;
        end
        ST_ADD: begin
          r_acc <= w_sum_sat;
          r_exp <= r_exp_new;
          r_ovf <= (r_ovf & ~r_first) | r_sat_al | w_add_ovf;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc;
  assign exp_out   = r_exp;
  assign ovf       = r_ovf;

endmodule
